// File: rtl/br_order_buf.sv
// -----------------------------------------------------------------------------
// br_order_buf -- in-order branch order buffer for the tournament predictor.
//
// Each conditional-branch prediction made in fetch is captured here with its
// metadata: PC, local/global/final directions, local history, BHR and RAS
// pointer. The entry is held until the branch retires. On retire the head
// entry is replayed, one cycle later, as the registered bob_* update bundle,
// together with the resolved direction and the chooser-update controls.
//
// Ports
//   clock, reset_n           core clock, asynchronous active-low reset
//   flush_rt_i               retire-stage flush; empties the buffer
//   alloc_*_i                allocation request and prediction metadata
//   rt_condbr_val_i          a conditional branch is retiring (pop head)
//   rt_brdir_i               resolved direction of the retiring branch
//   bob_stall_o              buffer full (combinational)
//   bob_count_o              occupancy, 0..DEPTH
//   bob_valid_o              update bundle valid (one cycle per retire)
//   bob_pc_o .. bob_mispred_o  registered update bundle payload
// -----------------------------------------------------------------------------
module br_order_buf #(
   parameter int DEPTH = 16,
   parameter int PTR_W = 4,
   parameter int LH_W  = 10,
   parameter int GH_W  = 12,
   parameter int RAS_W = 4
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               flush_rt_i,
   input  logic               alloc_val_i,
   input  logic [63:0]        alloc_pc_i,
   input  logic               alloc_lpred_i,
   input  logic               alloc_gpred_i,
   input  logic               alloc_fpred_i,
   input  logic [LH_W-1:0]    alloc_lochist_i,
   input  logic [GH_W-1:0]    alloc_bhr_i,
   input  logic [RAS_W-1:0]   alloc_rasptr_i,
   input  logic               rt_condbr_val_i,
   input  logic               rt_brdir_i,
   output logic               bob_stall_o,
   output logic [PTR_W:0]     bob_count_o,
   output logic               bob_valid_o,
   output logic [63:0]        bob_pc_o,
   output logic               bob_brdir_o,
   output logic               bob_chwe_o,
   output logic               bob_chdir_o,
   output logic [LH_W-1:0]    bob_lochist_o,
   output logic [GH_W-1:0]    bob_bhr_o,
   output logic [RAS_W-1:0]   bob_rasptr_o,
   output logic               bob_mispred_o
);

   // Per-branch payload held in the buffer
   typedef struct packed {
      logic [63:0]      pc;
      logic             lpred;
      logic             gpred;
      logic             fpred;
      logic [LH_W-1:0]  lochist;
      logic [GH_W-1:0]  bhr;
      logic [RAS_W-1:0] rasptr;
   } entry_t;

   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   CNT_ZERO = (PTR_W+1)'(0);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);

   // Chooser moves toward global only when the two component predictors
   // disagree; the direction says whether global turned out right.
   function automatic logic chooser_we(input logic lpred, input logic gpred);
      return lpred ^ gpred;
   endfunction

   function automatic logic chooser_dir(input logic gpred, input logic brdir);
      return (gpred == brdir);
   endfunction

   function automatic logic is_mispred(input logic fpred, input logic brdir);
      return (fpred != brdir);
   endfunction

   entry_t            mem_r [DEPTH];
   logic [DEPTH-1:0]  valid_r;
   logic [PTR_W-1:0]  rd_r;
   logic [PTR_W-1:0]  wr_r;
   logic [PTR_W:0]    count_r;

   logic              full_s;
   logic              retire_ok_s;
   logic              alloc_ok_s;
   entry_t            entry_in_s;
   entry_t            head_s;
   logic [PTR_W:0]    count_nxt_s;
   logic [DEPTH-1:0]  valid_nxt_s;

   assign full_s      = (count_r == CNT_FULL);
   assign retire_ok_s = rt_condbr_val_i && (count_r != CNT_ZERO);
   // A full buffer can still accept when the head leaves in the same cycle.
   assign alloc_ok_s  = alloc_val_i && !flush_rt_i && (!full_s || retire_ok_s);
   assign head_s      = mem_r[rd_r];
   assign bob_stall_o = full_s;
   assign bob_count_o = count_r;

   // Pack incoming prediction metadata into an entry
   always_comb begin
      entry_in_s         = '0;
      entry_in_s.pc      = alloc_pc_i;
      entry_in_s.lpred   = alloc_lpred_i;
      entry_in_s.gpred   = alloc_gpred_i;
      entry_in_s.fpred   = alloc_fpred_i;
      entry_in_s.lochist = alloc_lochist_i;
      entry_in_s.bhr     = alloc_bhr_i;
      entry_in_s.rasptr  = alloc_rasptr_i;
   end

   // Next occupancy: simultaneous alloc and retire cancel out
   always_comb begin
      count_nxt_s = count_r;
      case ({alloc_ok_s, retire_ok_s})
         2'b10:   count_nxt_s = count_r + CNT_ONE;
         2'b01:   count_nxt_s = count_r - CNT_ONE;
         default: count_nxt_s = count_r;
      endcase
   end

   // Next entry-valid vector; retire clears before alloc sets so a full
   // buffer with alloc+retire on the same slot ends up valid.
   always_comb begin
      valid_nxt_s = valid_r;
      if (retire_ok_s) begin
         valid_nxt_s[rd_r] = 1'b0;
      end else begin
         valid_nxt_s = valid_nxt_s;
      end
      if (alloc_ok_s) begin
         valid_nxt_s[wr_r] = 1'b1;
      end else begin
         valid_nxt_s = valid_nxt_s;
      end
   end

   // Entry payload storage; not reset, qualified by valid_r
   always_ff @(posedge clock) begin
      if (alloc_ok_s) begin
         mem_r[wr_r] <= entry_in_s;
      end
   end

   // Pointers, occupancy and valid bits; flush empties the buffer
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_r    <= PTR_ZERO;
         wr_r    <= PTR_ZERO;
         count_r <= CNT_ZERO;
         valid_r <= '0;
      end else if (flush_rt_i) begin
         rd_r    <= PTR_ZERO;
         wr_r    <= PTR_ZERO;
         count_r <= CNT_ZERO;
         valid_r <= '0;
      end else begin
         count_r <= count_nxt_s;
         valid_r <= valid_nxt_s;
         if (retire_ok_s) begin
            rd_r <= rd_r + PTR_ONE;
         end
         if (alloc_ok_s) begin
            wr_r <= wr_r + PTR_ONE;
         end
      end
   end

   // Registered update bundle; payload holds between retires. A retire in a
   // flush cycle is still reported.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bob_valid_o   <= 1'b0;
         bob_pc_o      <= 64'h0;
         bob_brdir_o   <= 1'b0;
         bob_chwe_o    <= 1'b0;
         bob_chdir_o   <= 1'b0;
         bob_lochist_o <= '0;
         bob_bhr_o     <= '0;
         bob_rasptr_o  <= '0;
         bob_mispred_o <= 1'b0;
      end else begin
         bob_valid_o <= retire_ok_s && valid_r[rd_r];
         if (retire_ok_s) begin
            bob_pc_o      <= head_s.pc;
            bob_brdir_o   <= rt_brdir_i;
            bob_chwe_o    <= chooser_we(head_s.lpred, head_s.gpred);
            bob_chdir_o   <= chooser_dir(head_s.gpred, rt_brdir_i);
            bob_lochist_o <= head_s.lochist;
            bob_bhr_o     <= head_s.bhr;
            bob_rasptr_o  <= head_s.rasptr;
            bob_mispred_o <= is_mispred(head_s.fpred, rt_brdir_i);
         end
      end
   end

endmodule

// File: doc/br_order_buf.md
Name: br_order_buf

Overview:
- In-order branch order buffer (BOB) on the opposite end of the tournament predictor interface.
- Captures per-branch prediction metadata when the predictor's second fetch stage emits a conditional-branch prediction.
- Holds the metadata until the branch retires, then replays it, plus the resolved direction and computed chooser-update controls, as the registered bob_* update bundle that feeds the predictor's update registers.
- Also raises back-pressure to fetch when full.

Parameters:
- DEPTH, 16, number of entries; power of 2, ≥2.
- PTR_W, 4, log2(DEPTH).
- LH_W, 10, local-history width.
- GH_W, 12, global-history (BHR) width.
- RAS_W, 4, RAS pointer width.

Ports:
- clock, in, 1, core clock.
- reset_n, in, 1, asynchronous active-low reset.
- flush_rt_i, in, 1, retire-stage flush; empties the buffer.
- alloc_val_i, in, 1, allocate request: conditional branch predicted in fetch stage 1.
- alloc_pc_i, in, 64, branch PC.
- alloc_lpred_i, in, 1, local-predictor direction.
- alloc_gpred_i, in, 1, global-predictor direction.
- alloc_fpred_i, in, 1, final (chosen) direction.
- alloc_lochist_i, in, LH_W, local history used for the prediction.
- alloc_bhr_i, in, GH_W, BHR value used for the prediction.
- alloc_rasptr_i, in, RAS_W, RAS pointer snapshot.
- rt_condbr_val_i, in, 1, conditional branch retiring (pop head).
- rt_brdir_i, in, 1, resolved direction of the retiring branch.
- bob_stall_o, out, 1, buffer full.
- bob_count_o, out, PTR_W+1, occupancy.
- bob_valid_o, out, 1, update bundle valid.
- bob_pc_o, out, 64, PC of the retired branch.
- bob_brdir_o, out, 1, resolved direction.
- bob_chwe_o, out, 1, chooser-table write enable.
- bob_chdir_o, out, 1, chooser update direction (1 = global was correct).
- bob_lochist_o, out, LH_W, stored local history.
- bob_bhr_o, out, GH_W, stored BHR.
- bob_rasptr_o, out, RAS_W, stored RAS pointer.
- bob_mispred_o, out, 1, final prediction differed from resolved direction.

Behaviour:
- Storage: circular FIFO with head pointer (rd), tail pointer (wr), and count. Pointers wrap modulo DEPTH. count ranges 0..DEPTH.

Reset:
- Pointers, count, every entry's valid bit, and all outputs go to 0.
- Entry payload contents need not be reset.

Allocate:
- Accepted iff alloc_val_i && !flush_rt_i && (count<DEPTH || retire_ok).
- Accepted allocation writes the entry at wr and increments wr.
- Request while full without a same-cycle retire is dropped, with no state change. Fetch must honour bob_stall_o.

Retire:
- retire_ok = rt_condbr_val_i && count!=0.
- On retire_ok, the head entry is read and rd increments.
- rt_condbr_val_i with count==0 is ignored; bob_valid_o stays 0 next cycle.

Count update:
- +1 on alloc only, -1 on retire only, unchanged when both or neither occur.
- Full with simultaneous alloc+retire: both occur, count stays DEPTH.
- Empty with simultaneous alloc+retire: retire ignored, alloc accepted, count becomes 1.

Update bundle (latency 1):
- All bob_* outputs are registered and driven the cycle after retire_ok.
- bob_valid_o=1 for exactly one cycle per retire_ok; otherwise 0.
- Payload outputs hold their last value when bob_valid_o=0.
- bob_brdir_o = rt_brdir_i.
- bob_chwe_o = lpred XOR gpred (update the chooser only on disagreement).
- bob_chdir_o = (gpred == rt_brdir_i).
- bob_mispred_o = (fpred != rt_brdir_i).
- pc, lochist, bhr, and rasptr are copied from the head entry.

Flush:
- flush_rt_i in cycle T: a retire_ok in T is still processed and its bundle is emitted in T+1.
- Any allocation in T is dropped.
- At the edge after T: rd=wr=0, count=0, all entry valid bits cleared.

bob_stall_o:
- Combinational, equals (count==DEPTH).
- Not asserted during the flush cycle if count was <DEPTH.

Reset mid-operation:
- Asynchronous reset clears all state immediately.
- Any pending bundle is lost and bob_valid_o drops to 0 without waiting for a clock edge.

Test Plan:
- Single branch: alloc pc=0x1000, lpred=1, gpred=0, fpred=1, lochist=0x155, bhr=0xABC, rasptr=3; retire with brdir=0 → next cycle bob_valid_o=1, bob_pc_o=0x1000, bob_chwe_o=1, bob_chdir_o=1, bob_mispred_o=1, bob_bhr_o=0xABC, bob_rasptr_o=3; one cycle later bob_valid_o=0.
- Fill: 16 allocs with no retire → bob_count_o=16, bob_stall_o=1; a 17th alloc is dropped. Then retire 16 times with brdir=1 → PCs emerge in allocation order, count returns to 0, bob_stall_o deasserts after the first retire.
- Full with simultaneous alloc+retire: count stays 16, oldest entry emitted; the new entry retires last after 15 further retires.
- Wrap-around: 10 allocs, 10 retires, 10 allocs (pointer wraps past 15) → retire order and payloads correct; lpred=gpred=1 entries give bob_chwe_o=0.
- Flush with 5 entries plus same-cycle retire and alloc → retire bundle emitted next cycle, alloc dropped, count=0; a subsequent spurious rt_condbr_val_i produces no bob_valid_o.
- Assert reset_n low while 3 entries are held and a bundle is pending → all outputs 0 asynchronously; after release, count=0 and retire on empty yields no bundle.
